eth_tx_fcs_inserter: RTL and testbench

Ethernet TX framing stage that sits directly upstream of the MAC byte output.
- Accepts a frame payload as a byte stream (destination MAC through end of payload).
- Zero-pads the frame to the minimum length and appends the 4-byte IEEE 802.3 FCS.
- Computes the FCS on the fly with the reflected CRC-32 (poly 0x04C11DB7, init 0xFFFFFFFF, refin/refout, final XOR).
- Emits the completed frame on a registered valid/ready stream with no gaps under continuous ready.

---
 rtl/eth_pkg.sv | 28 ++
 rtl/crc32_byte_step.sv | 19 +
 rtl/eth_tx_fcs_inserter.sv | 154 +++++++++++++++
 tb/tb_eth_tx_fcs_inserter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet framing definitions: CRC-32 constants, minimum frame length and TX state encoding.
package eth_pkg;

    localparam logic [31:0] CRC32_POLY     = 32'h04C11DB7;
    localparam logic [31:0] CRC32_POLY_REV = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT     = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_XOROUT   = 32'hFFFFFFFF;

    localparam int ETH_MIN_LEN = 60;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PAD,
        FCS
    } tx_state_e;

    // Bit-reverse a normal-form polynomial into the form used by the LSB-first update.
    function automatic logic [31:0] reflect32(input logic [31:0] value);
        logic [31:0] result;
        result = '0;
        for (int i = 0; i < 32; i++) begin
            result[i] = value[31-i];
        end
        return result;
    endfunction

endpackage

// File: rtl/crc32_byte_step.sv
// One full byte of reflected CRC-32 update, purely combinational; shared by the TX inserter and RX checker.
module crc32_byte_step
    import eth_pkg::*;
#(
    parameter logic [31:0] POLY_REV = CRC32_POLY_REV
) (
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    always_comb begin
        crc_out = crc_in;
        for (int i = 0; i < 8; i++) begin
            crc_out = (crc_out >> 1) ^ (POLY_REV & {32{crc_out[0] ^ data[i]}});
        end
    end

endmodule

// File: rtl/eth_tx_fcs_inserter.sv
// Ethernet TX framing stage: passes payload through, zero-pads to the minimum length
// and appends the IEEE 802.3 FCS on a registered valid/ready output.
module eth_tx_fcs_inserter
    import eth_pkg::*;
#(
    parameter int          DATALEN  = 8,
    parameter int          CRC_LEN  = 32,
    parameter logic [31:0] CRC_POLY = CRC32_POLY,
    parameter int          MIN_LEN  = ETH_MIN_LEN,
    parameter int          CNT_W    = 11
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DATALEN-1:0] s_data,
    input  logic               s_valid,
    input  logic               s_last,
    output logic               s_ready,
    output logic [DATALEN-1:0] m_data,
    output logic               m_valid,
    output logic               m_last,
    input  logic               m_ready,
    output logic               crc_busy
);

    localparam logic [31:0]  POLY_REV = reflect32(CRC_POLY);
    localparam logic [CNT_W:0] MIN_CNT = (CNT_W+1)'(MIN_LEN);

    tx_state_e           state;
    tx_state_e           state_next;
    logic [CRC_LEN-1:0]  crc_acc;
    logic [CRC_LEN-1:0]  crc_step;
    logic [CRC_LEN-1:0]  fcs;
    logic [CNT_W-1:0]    byte_cnt;
    logic [CNT_W-1:0]    cnt_next;
    logic [CNT_W:0]      cnt_inc;
    logic [1:0]          fcs_idx;
    logic [DATALEN-1:0]  crc_data;
    logic [DATALEN-1:0]  fcs_byte;
    logic                out_free;
    logic                accept;
    logic                emit_pad;
    logic                emit_fcs;
    logic                fcs_done;

    assign out_free = !m_valid || m_ready;
    assign accept   = s_valid && s_ready;
    assign fcs_done = emit_fcs && (fcs_idx == 2'd3);

    assign cnt_inc  = {1'b0, byte_cnt} + (CNT_W+1)'(1);
    // Counter only needs to reach MIN_LEN, so it sticks there and long frames never wrap it.
    assign cnt_next = ({1'b0, byte_cnt} >= MIN_CNT) ? byte_cnt : cnt_inc[CNT_W-1:0];

    assign crc_data = emit_pad ? '0 : s_data;
    assign fcs      = crc_acc ^ CRC32_XOROUT;
    assign fcs_byte = DATALEN'(fcs >> {fcs_idx, 3'b000});

    crc32_byte_step #(
        .POLY_REV(POLY_REV)
    ) u_crc_step (
        .crc_in  (crc_acc),
        .data    (crc_data),
        .crc_out (crc_step)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE, DATA: begin
                if (accept) begin
                    if (s_last) begin
                        state_next = (cnt_inc < MIN_CNT) ? PAD : FCS;
                    end else begin
                        state_next = DATA;
                    end
                end
            end
            PAD: begin
                if (out_free && (cnt_inc >= MIN_CNT)) begin
                    state_next = FCS;
                end
            end
            FCS: begin
                if (fcs_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        s_ready  = 1'b0;
        emit_pad = 1'b0;
        emit_fcs = 1'b0;
        unique case (state)
            IDLE, DATA: s_ready  = out_free && rst;
            PAD:        emit_pad = out_free;
            FCS:        emit_fcs = out_free;
            default:    s_ready  = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            crc_acc  <= CRC32_INIT;
            byte_cnt <= '0;
            fcs_idx  <= '0;
            m_data   <= '0;
            m_valid  <= 1'b0;
            m_last   <= 1'b0;
            crc_busy <= 1'b0;
        end else begin
            if (out_free) begin
                m_valid <= accept || emit_pad || emit_fcs;
                m_last  <= fcs_done;
                if (accept) begin
                    m_data <= s_data;
                end else if (emit_pad) begin
                    m_data <= '0;
                end else if (emit_fcs) begin
                    m_data <= fcs_byte;
                end
            end

            if (accept || emit_pad) begin
                crc_acc  <= crc_step;
                byte_cnt <= cnt_next;
            end

            if (emit_fcs) begin
                fcs_idx <= fcs_idx + 2'd1;
                if (fcs_done) begin
                    crc_acc  <= CRC32_INIT;
                    byte_cnt <= '0;
                end
            end

            if (accept) begin
                crc_busy <= 1'b1;
            end else if (m_valid && m_ready && m_last) begin
                crc_busy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_eth_tx_fcs_inserter.sv
// Randomized self-checking bench: two inserters (no padding and 60-byte minimum) against a frame-level reference model.
module tb_eth_tx_fcs_inserter;

    typedef logic [8:0] beat_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       m_ready;
    int         sel;

    logic       s_valid0, s_ready0, m_valid0, m_last0, crc_busy0;
    logic       s_valid60, s_ready60, m_valid60, m_last60, crc_busy60;
    logic [7:0] m_data0, m_data60;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    assign s_valid0  = s_valid && (sel == 0);
    assign s_valid60 = s_valid && (sel == 1);

    eth_tx_fcs_inserter #(.MIN_LEN(0)) dut0 (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_valid(s_valid0), .s_last(s_last), .s_ready(s_ready0),
        .m_data(m_data0), .m_valid(m_valid0), .m_last(m_last0), .m_ready(m_ready),
        .crc_busy(crc_busy0)
    );

    eth_tx_fcs_inserter #(.MIN_LEN(60)) dut60 (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_valid(s_valid60), .s_last(s_last), .s_ready(s_ready60),
        .m_data(m_data60), .m_valid(m_valid60), .m_last(m_last60), .m_ready(m_ready),
        .crc_busy(crc_busy60)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Standard bitwise reflected CRC-32 over a whole frame, final complement applied.
    function automatic logic [31:0] refFcs(input logic [7:0] frame[$]);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (frame[i]) begin
            c = c ^ {24'h0, frame[i]};
            for (int k = 0; k < 8; k++) begin
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            end
        end
        return ~c;
    endfunction

    task automatic expectFrame(input logic [7:0] payload[$], input int min_len, output beat_t exp[$]);
        logic [7:0]  frame[$];
        logic [31:0] f;
        frame = payload;
        while (frame.size() < min_len) frame.push_back(8'h00);
        f = refFcs(frame);
        exp = {};
        foreach (frame[i]) exp.push_back({1'b0, frame[i]});
        for (int k = 0; k < 4; k++) exp.push_back({k == 3, f[8*k +: 8]});
    endtask

    task automatic makeStim(input logic [7:0] payload[$], output beat_t stim[$]);
        stim = {};
        foreach (payload[i]) stim.push_back({i == payload.size() - 1, payload[i]});
    endtask

    task automatic compareBeats(input string tag, input beat_t got[$], input beat_t exp[$]);
        checkOutput({tag, "_len"}, got.size(), exp.size());
        for (int i = 0; i < got.size() && i < exp.size(); i++) begin
            checkOutput($sformatf("%s[%0d]", tag, i), got[i], exp[i]);
        end
    endtask

    // Called at a falling edge; drives one input beat per cycle and records every output handshake.
    task automatic applyStimulus(input int s, input beat_t stim[$], input int ready_pct,
                                 input int abort_at, output beat_t got[$], output int gaps);
        int    idx = 0;
        int    cyc = 0;
        int    lasts = 0;
        int    need = 0;
        bit    done = 0;
        bit    prev_stall = 0;
        beat_t prev_beat = '0;
        logic  rdy, mv, ml, busy;
        logic [7:0] md;
        foreach (stim[i]) if (stim[i][8]) need++;
        got = {};
        gaps = 0;
        sel = s;
        while (!done && cyc < 5000) begin
            s_valid = (idx < stim.size());
            s_data  = s_valid ? stim[idx][7:0] : 8'h00;
            s_last  = s_valid ? stim[idx][8] : 1'b0;
            m_ready = ($urandom_range(0, 99) < ready_pct);
            #1;
            if (s == 0) begin
                rdy = s_ready0;  mv = m_valid0;  ml = m_last0;  md = m_data0;  busy = crc_busy0;
            end else begin
                rdy = s_ready60; mv = m_valid60; ml = m_last60; md = m_data60; busy = crc_busy60;
            end
            if (prev_stall) checkOutput("hold", {mv, ml, md}, {1'b1, prev_beat});
            prev_stall = mv && !m_ready;
            prev_beat  = {ml, md};
            if (s_valid && !rdy) gaps++;
            if (s_valid && rdy) idx++;
            if (mv && m_ready) begin
                if (got.size() == 0) checkOutput("busy_mid", busy, 1);
                got.push_back({ml, md});
                if (ml) lasts++;
                if (lasts == need) done = 1;
                if (abort_at > 0 && got.size() == abort_at) done = 1;
            end
            @(negedge clk);
            cyc++;
        end
        s_valid = 0;
        s_last  = 0;
        m_ready = 1;
        checkOutput("run_done", done, 1);
    endtask

    task automatic runFrame(input int s, input logic [7:0] payload[$], input int pct,
                            input string tag, output beat_t got[$]);
        beat_t stim[$];
        beat_t exp[$];
        int    gaps;
        makeStim(payload, stim);
        applyStimulus(s, stim, pct, 0, got, gaps);
        expectFrame(payload, (s == 0) ? 0 : 60, exp);
        compareBeats(tag, got, exp);
        #1;
        checkOutput({tag, "_busy_end"}, (s == 0) ? crc_busy0 : crc_busy60, 0);
        @(negedge clk);
    endtask

    task automatic randomPayload(input int len, output logic [7:0] p[$]);
        p = {};
        for (int i = 0; i < len; i++) p.push_back(8'($urandom_range(0, 255)));
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] pay[$];
        logic [7:0] pay_b[$];
        logic [7:0] known[4];
        beat_t      got[$];
        beat_t      got_b[$];
        beat_t      stim[$];
        beat_t      stim_b[$];
        beat_t      exp[$];
        beat_t      exp_b[$];
        int         gaps;
        int         nlast;

        known[0] = 8'h26; known[1] = 8'h39; known[2] = 8'hF4; known[3] = 8'hCB;
        rst = 0; s_valid = 0; s_data = 0; s_last = 0; m_ready = 1; sel = 0;

        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_s_ready0",  s_ready0,   0);
        checkOutput("rst_s_ready60", s_ready60,  0);
        checkOutput("rst_m_valid0",  m_valid0,   0);
        checkOutput("rst_m_valid60", m_valid60,  0);
        checkOutput("rst_m_last0",   m_last0,    0);
        checkOutput("rst_m_data60",  m_data60,   0);
        checkOutput("rst_busy0",     crc_busy0,  0);
        checkOutput("rst_busy60",    crc_busy60, 0);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        #1;
        checkOutput("idle_s_ready0",  s_ready0,  1);
        checkOutput("idle_s_ready60", s_ready60, 1);
        @(negedge clk);

        // "123456789" with no padding: well-known CRC-32 0xCBF43926 sent LSB first.
        pay = {};
        for (int i = 0; i < 9; i++) pay.push_back(8'(8'h31 + i));
        runFrame(0, pay, 100, "check9", got);
        for (int k = 0; k < 4; k++) checkOutput($sformatf("check9_fcs%0d", k), got[9+k], {k == 3, known[k]});

        pay = {8'hAB};
        runFrame(1, pay, 100, "single_pad", got);

        pay = {};
        for (int i = 0; i < 60; i++) pay.push_back(8'(i));
        runFrame(1, pay, 100, "exact60", got);
        pay.push_back(8'd60);
        runFrame(1, pay, 100, "len61", got);

        randomPayload(100, pay);
        runFrame(1, pay, 100, "len100_rdy", got);
        runFrame(1, pay, 50, "len100_stall", got_b);
        compareBeats("len100_same", got_b, got);

        // Abort mid-frame with reset; nothing of that frame's FCS may reach the output.
        randomPayload(40, pay);
        makeStim(pay, stim);
        applyStimulus(0, stim, 100, 20, got, gaps);
        nlast = 0;
        foreach (got[i]) if (got[i][8]) nlast++;
        checkOutput("abort_beats", got.size(), 20);
        checkOutput("abort_nolast", nlast, 0);
        rst = 0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("abort_m_valid", m_valid0, 0);
        checkOutput("abort_m_last", m_last0, 0);
        checkOutput("abort_busy", crc_busy0, 0);
        rst = 1;
        @(negedge clk);
        pay = {};
        for (int i = 0; i < 9; i++) pay.push_back(8'(8'h31 + i));
        runFrame(0, pay, 100, "after_abort", got);
        for (int k = 0; k < 4; k++) checkOutput($sformatf("after_abort_fcs%0d", k), got[9+k], {k == 3, known[k]});

        // Two 64-byte frames back to back: only the 4 FCS cycles hold off the second frame.
        randomPayload(64, pay);
        randomPayload(64, pay_b);
        makeStim(pay, stim);
        makeStim(pay_b, stim_b);
        foreach (stim_b[i]) stim.push_back(stim_b[i]);
        applyStimulus(1, stim, 100, 0, got, gaps);
        expectFrame(pay, 60, exp);
        expectFrame(pay_b, 60, exp_b);
        foreach (exp_b[i]) exp.push_back(exp_b[i]);
        compareBeats("b2b", got, exp);
        checkOutput("b2b_gap", gaps, 4);

        for (int r = 0; r < 6; r++) begin
            randomPayload($urandom_range(1, 80), pay);
            runFrame($urandom_range(0, 1), pay, $urandom_range(30, 100), $sformatf("rand%0d", r), got);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
